// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the data-memory responder slice.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dresp_state_t;

    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between a core and its data-memory responder.
interface dmem_responder_if;
    import cpu_types_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    logic  datomic;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dhit, dmemload
    );

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

endinterface

// File: rtl/link_tracker.sv
// LL/SC reservation: one linked word index plus its valid flag.
module link_tracker
#(
    parameter int unsigned AW = 6
)
(
    input  logic          CLK,
    input  logic          nRST,
    input  logic          set,
    input  logic          clear,
    input  logic          snoop_hit,
    input  logic [AW-1:0] idx,
    output logic          link_valid,
    output logic [AW-1:0] link_idx
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_idx   <= '0;
        end else begin
            if (set) begin
                link_idx <= idx;
            end
            // A coinciding snoop or clear always wins over a new link.
            if (clear | snoop_hit) begin
                link_valid <= 1'b0;
            end else if (set) begin
                link_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a flop-array backing store and LL/SC support.
module dmem_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT = 2,
    parameter int unsigned AW  = 6
)
(
    input  logic           CLK,
    input  logic           nRST,
    input  logic           halt,
    input  logic           snoop_wen,
    input  word_t          snoop_addr,
    dmem_responder_if.slave dif
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam cnt_t        LAT_LAST = (LAT > 0) ? cnt_t'(LAT - 1) : '0;

    typedef logic [AW-1:0] idx_t;

    dresp_state_t state, state_n;
    cnt_t         cnt, cnt_n;

    logic  req_ren;
    logic  req_wen;
    logic  req_atomic;
    idx_t  req_idx;
    word_t req_data;

    word_t mem [DEPTH];

    logic  request;
    logic  accept;
    logic  resp;
    idx_t  cur_idx;
    idx_t  snoop_idx;

    logic  link_valid;
    idx_t  link_idx;
    logic  is_ll;
    logic  is_sc;
    logic  is_wr;
    logic  snoop_link_hit;
    logic  sc_ok;
    logic  commit;
    logic  link_clear;
    logic  link_snoop;

    logic  unused_addr_bits;

    assign request   = dif.dmemREN | dif.dmemWEN;
    assign cur_idx   = dif.dmemaddr[AW+1:2];
    assign snoop_idx = snoop_addr[AW+1:2];

    assign unused_addr_bits = ^{dif.dmemaddr[31:AW+2], dif.dmemaddr[1:0],
                                snoop_addr[31:AW+2], snoop_addr[1:0]};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        resp    = 1'b0;
        case (state)
            IDLE: begin
                if (request && !halt) begin
                    accept  = 1'b1;
                    cnt_n   = '0;
                    state_n = (LAT > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!request) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAT_LAST) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            RESP: begin
                resp    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Write has priority when both enables are raised together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_ren    <= 1'b0;
            req_wen    <= 1'b0;
            req_atomic <= 1'b0;
            req_idx    <= '0;
            req_data   <= '0;
        end else if (accept) begin
            req_ren    <= dif.dmemREN & ~dif.dmemWEN;
            req_wen    <= dif.dmemWEN;
            req_atomic <= dif.datomic;
            req_idx    <= cur_idx;
            req_data   <= dif.dmemstore;
        end
    end

    assign is_ll = resp & req_ren & req_atomic;
    assign is_sc = resp & req_wen & req_atomic;
    assign is_wr = resp & req_wen & ~req_atomic;

    assign snoop_link_hit = snoop_wen & (snoop_idx == link_idx);
    assign sc_ok          = link_valid & (link_idx == req_idx) & ~snoop_link_hit;
    assign commit         = is_wr | (is_sc & sc_ok);
    assign link_clear     = is_sc | (is_wr & (req_idx == link_idx));
    // An LL completing this cycle is exposed to snoops on the index it is about to link.
    assign link_snoop     = snoop_wen & (snoop_idx == (is_ll ? req_idx : link_idx));

    link_tracker #(
        .AW (AW)
    ) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (is_ll),
        .clear      (link_clear),
        .snoop_hit  (link_snoop),
        .idx        (req_idx),
        .link_valid (link_valid),
        .link_idx   (link_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[idx_t'(i)] <= '0;
            end
        end else if (commit) begin
            mem[req_idx] <= req_data;
        end
    end

    assign dif.dhit = resp;

    always_comb begin
        dif.dmemload = '0;
        if (resp) begin
            if (req_wen & req_atomic) begin
                dif.dmemload = {31'b0, sc_ok};
            end else if (req_ren) begin
                dif.dmemload = mem[req_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  halt;
    logic  snoop_wen;
    word_t snoop_addr;

    int tests = 0;
    int fails = 0;

    word_t       m_mem [DEPTH];
    bit          m_lv;
    int unsigned m_li;

    dmem_responder_if dif();

    dmem_responder #(
        .LAT (LAT),
        .AW  (AW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .halt       (halt),
        .snoop_wen  (snoop_wen),
        .snoop_addr (snoop_addr),
        .dif        (dif)
    );

    always #5 CLK = ~CLK;

    function automatic int unsigned widx(input word_t a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic word_t rand_addr();
        word_t a;
        a = $urandom & ~32'h0000_00FC;
        return a | (word_t'($urandom_range(0, 7)) << 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_lv = 0;
        m_li = 0;
    endtask

    task automatic idle_inputs();
        dif.dmemREN   = 1'b0;
        dif.dmemWEN   = 1'b0;
        dif.datomic   = 1'b0;
        dif.dmemaddr  = '0;
        dif.dmemstore = '0;
    endtask

    // One full transaction; optionally a snoop write is raised during the response cycle.
    task automatic do_req(input bit ren, input bit wen, input bit atomic, input word_t addr,
                          input word_t data, input bit snoop_resp, input word_t saddr,
                          input string name);
        word_t       exp;
        bit          chk_load;
        bit          ok;
        bit          seen;
        int          n;
        int unsigned idx;
        int unsigned sidx;
        idx      = widx(addr);
        sidx     = widx(saddr);
        chk_load = 1;
        exp      = '0;
        if (wen) begin
            if (atomic) begin
                ok = m_lv && (m_li == idx) && !(snoop_resp && sidx == m_li);
                if (ok) m_mem[idx] = data;
                exp  = ok ? 32'd1 : 32'd0;
                m_lv = 0;
            end else begin
                m_mem[idx] = data;
                chk_load   = 0;
                if (idx == m_li) m_lv = 0;
                if (snoop_resp && sidx == m_li) m_lv = 0;
            end
        end else begin
            exp = m_mem[idx];
            if (atomic) begin
                m_li = idx;
                m_lv = !(snoop_resp && sidx == idx);
            end else if (snoop_resp && sidx == m_li) begin
                m_lv = 0;
            end
        end

        dif.dmemREN   = ren;
        dif.dmemWEN   = wen;
        dif.datomic   = atomic;
        dif.dmemaddr  = addr;
        dif.dmemstore = data;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge CLK);
            n++;
            #1;
            if (snoop_resp && n == LAT + 1) begin
                snoop_wen  = 1'b1;
                snoop_addr = saddr;
            end
            @(negedge CLK);
            if (dif.dhit) seen = 1;
        end
        tests++;
        if (!seen || n != LAT + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, n, seen, LAT + 1);
        end
        if (chk_load) begin
            tests++;
            if (dif.dmemload !== exp) begin
                fails++;
                $display("FAIL %s dmemload: got %h, expected %h", name, dif.dmemload, exp);
            end
        end
        @(posedge CLK);
        #1;
        idle_inputs();
        snoop_wen = 1'b0;
        @(negedge CLK);
        tests++;
        if (dif.dhit !== 1'b0 || dif.dmemload !== '0) begin
            fails++;
            $display("FAIL %s after-resp: dhit=%b dmemload=%h, expected 0/0", name, dif.dhit, dif.dmemload);
        end
    endtask

    task automatic snoop_pulse(input word_t saddr);
        snoop_wen  = 1'b1;
        snoop_addr = saddr;
        if (widx(saddr) == m_li) m_lv = 0;
        @(posedge CLK);
        #1;
        snoop_wen = 1'b0;
    endtask

    task automatic test_reset();
        nRST       = 1'b0;
        halt       = 1'b0;
        snoop_wen  = 1'b0;
        snoop_addr = '0;
        idle_inputs();
        model_reset();
        #12;
        tests++;
        if (dif.dhit !== 1'b0) begin
            fails++;
            $display("FAIL reset dhit: got %b, expected 0", dif.dhit);
        end
        tests++;
        if (dif.dmemload !== '0) begin
            fails++;
            $display("FAIL reset dmemload: got %h, expected 0", dif.dmemload);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) do_req(1, 0, 0, rand_addr(), '0, 0, '0, "reset_read");
    endtask

    task automatic test_rw();
        do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, '0, "rw_write");
        do_req(1, 0, 0, 32'h10, '0, 0, '0, "rw_read");
        do_req(1, 1, 0, 32'hFFFF_FF13, 32'h1234_5678, 0, '0, "rw_both_is_write");
        do_req(1, 0, 0, 32'h10, '0, 0, '0, "rw_alias_read");
    endtask

    task automatic test_llsc();
        do_req(1, 0, 1, 32'h20, '0, 0, '0, "ll");
        do_req(0, 1, 1, 32'h20, 32'd5, 0, '0, "sc_ok");
        do_req(1, 0, 0, 32'h20, '0, 0, '0, "sc_ok_read");
        do_req(1, 0, 1, 32'h20, '0, 0, '0, "ll2");
        snoop_pulse(32'h20);
        do_req(0, 1, 1, 32'h20, 32'd7, 0, '0, "sc_snooped");
        do_req(1, 0, 0, 32'h20, '0, 0, '0, "sc_snooped_read");
        do_req(1, 0, 1, 32'h24, '0, 1, 32'h24, "ll_snoop_same_cycle");
        do_req(0, 1, 1, 32'h24, 32'd9, 0, '0, "sc_after_ll_snoop");
        do_req(1, 0, 1, 32'h28, '0, 0, '0, "ll3");
        do_req(0, 1, 1, 32'h28, 32'd11, 1, 32'h28, "sc_snoop_same_cycle");
        do_req(1, 0, 1, 32'h30, '0, 0, '0, "ll4");
        do_req(0, 1, 0, 32'h30, 32'd13, 0, '0, "plain_write_link");
        do_req(0, 1, 1, 32'h30, 32'd15, 0, '0, "sc_after_write");
        do_req(1, 0, 0, 32'h30, '0, 0, '0, "sc_after_write_read");
    endtask

    task automatic test_flush();
        word_t a;
        bit    bad;
        a = rand_addr();
        dif.dmemWEN   = 1'b1;
        dif.dmemaddr  = a;
        dif.dmemstore = $urandom;
        @(posedge CLK);
        #1;
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (dif.dhit !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL flush dhit: got a strobe, expected none");
        end
        do_req(1, 0, 0, a, '0, 0, '0, "flush_read");
    endtask

    task automatic test_reset_mid();
        dif.dmemWEN   = 1'b1;
        dif.dmemaddr  = 32'h04;
        dif.dmemstore = 32'hCAFE_F00D;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        tests++;
        if (dif.dhit !== 1'b0 || dif.dmemload !== '0) begin
            fails++;
            $display("FAIL reset_wait outputs: dhit=%b dmemload=%h, expected 0/0", dif.dhit, dif.dmemload);
        end
        idle_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        do_req(1, 0, 0, 32'h04, '0, 0, '0, "reset_wait_read");

        do_req(0, 1, 0, 32'h08, 32'h5555_AAAA, 0, '0, "pre_resp_reset_write");
        dif.dmemREN  = 1'b1;
        dif.dmemaddr = 32'h08;
        for (int i = 0; i < LAT + 1; i++) @(negedge CLK);
        tests++;
        if (dif.dhit !== 1'b1 || dif.dmemload !== 32'h5555_AAAA) begin
            fails++;
            $display("FAIL reset_resp pre: dhit=%b dmemload=%h, expected 1/5555aaaa", dif.dhit, dif.dmemload);
        end
        nRST = 1'b0;
        #1;
        tests++;
        if (dif.dhit !== 1'b0 || dif.dmemload !== '0) begin
            fails++;
            $display("FAIL reset_resp outputs: dhit=%b dmemload=%h, expected 0/0", dif.dhit, dif.dmemload);
        end
        idle_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        do_req(1, 0, 0, 32'h08, '0, 0, '0, "reset_resp_read");
    endtask

    task automatic test_halt();
        word_t a;
        bit    bad;
        int    n;
        bit    seen;
        a    = rand_addr();
        halt = 1'b1;
        dif.dmemREN  = 1'b1;
        dif.dmemaddr = a;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (dif.dhit !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL halt_block dhit: got a strobe, expected none");
        end
        halt = 1'b0;
        @(posedge CLK);
        #1;
        halt = 1'b1;
        n    = 1;
        seen = 0;
        @(negedge CLK);
        while (!seen && n < 40) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (dif.dhit) seen = 1;
        end
        tests++;
        if (!seen || n != LAT + 1 || dif.dmemload !== m_mem[widx(a)]) begin
            fails++;
            $display("FAIL halt_inflight: seen=%0d cycles=%0d data=%h, expected 1/%0d/%h",
                     seen, n, dif.dmemload, LAT + 1, m_mem[widx(a)]);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (dif.dhit !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL halt_single dhit: got extra strobe, expected one");
        end
        idle_inputs();
        halt = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        word_t a;
        int    n;
        int    hits;
        int    hit_n [2];
        bit    bad;
        a = rand_addr();
        do_req(0, 1, 0, a, $urandom, 0, '0, "b2b_write");
        dif.dmemREN  = 1'b1;
        dif.dmemaddr = a;
        n    = 0;
        hits = 0;
        bad  = 0;
        hit_n[0] = 0;
        hit_n[1] = 0;
        while (hits < 2 && n < 40) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (dif.dhit) begin
                hit_n[hits] = n;
                hits++;
                if (dif.dmemload !== m_mem[widx(a)]) bad = 1;
            end
        end
        @(posedge CLK);
        #1;
        idle_inputs();
        tests++;
        if (hits != 2 || hit_n[0] != LAT + 1 || hit_n[1] - hit_n[0] != LAT + 2 || bad) begin
            fails++;
            $display("FAIL back_to_back: hits=%0d first=%0d gap=%0d data_bad=%0d, expected 2/%0d/%0d/0",
                     hits, hit_n[0], hit_n[1] - hit_n[0], bad, LAT + 1, LAT + 2);
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        int unsigned op;
        bit          ren;
        bit          wen;
        bit          at;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 4);
            ren = (op == 0) || (op == 2) || (op == 4);
            wen = (op == 1) || (op == 3) || (op == 4);
            at  = (op == 2) || (op == 3) || (op == 4 && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) snoop_pulse(rand_addr());
            do_req(ren, wen, at, rand_addr(), $urandom, $urandom_range(0, 3) == 0,
                   rand_addr(), "random");
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_llsc();
        test_flush();
        test_reset_mid();
        test_halt();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning the number of wait cycles between request acceptance and the response state (legal range 0..15).
REQ-002 The block SHALL have parameter AW, default 6, meaning the word-address width (backing store depth 2**AW words).
REQ-003 The block SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nRST  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port dmemREN  in  1  read request from the memory stage.
REQ-006 The block SHALL have port dmemWEN  in  1  write request from the memory stage.
REQ-007 The block SHALL have port datomic  in  1  the request is LL (with REN) or SC (with WEN).
REQ-008 The block SHALL have port dmemaddr  in  32  byte address.
REQ-009 The block SHALL have port dmemstore  in  32  write data.
REQ-010 The block SHALL have port halt  in  1  core halted; no new requests are accepted.
REQ-011 The block SHALL have port snoop_wen  in  1  the other core wrote snoop_addr this cycle.
REQ-012 The block SHALL have port snoop_addr  in  32  byte address of the other core's write.
REQ-013 The block SHALL have port dhit  out  1  one-cycle response strobe.
REQ-014 The block SHALL have port dmemload  out  32  read data or SC result, valid only while dhit=1 and 0 otherwise.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with (dmemREN|dmemWEN)=1 and halt=0, the block SHALL latch the request and go to WAIT if LAT>0, else to RESP.
REQ-017 In WAIT, a 4-bit counter SHALL count LAT cycles and then go to RESP, so a request sampled in cycle t gets dhit in cycle t+LAT+1.
REQ-018 In RESP, dhit SHALL be 1 for exactly one cycle, any write SHALL commit in that cycle, and the next state SHALL be IDLE.
REQ-019 A request sampled in IDLE SHALL wait at least one cycle after RESP before being accepted (no back-to-back re-serve).
REQ-020 In WAIT, if dmemREN and dmemWEN are both low (flush), the transaction SHALL abort: no write, no dhit, return to IDLE.
REQ-021 When dmemREN=1 and dmemWEN=1 together, the request SHALL be treated as a write.
REQ-022 The word index SHALL be dmemaddr[AW+1:2]; dmemaddr[1:0] and the upper bits SHALL be ignored, so addresses alias modulo 2**AW words.
REQ-023 A plain read SHALL return mem[index] on dmemload during RESP.
REQ-024 A plain write SHALL store dmemstore to mem[index] at the end of RESP.
REQ-025 An LL (REN&datomic) SHALL return data as a read and, at RESP, set link_valid=1 and link_idx=index.
REQ-026 An SC (WEN&datomic) SHALL succeed iff link_valid=1 and link_idx=index: on success it writes and returns dmemload=1, otherwise it does not write and returns 0.
REQ-027 Every SC SHALL clear link_valid at RESP.
REQ-028 A plain write to link_idx SHALL clear link_valid at RESP.
REQ-029 A snoop_wen with a snoop_addr word index equal to link_idx SHALL clear link_valid in that cycle.
REQ-030 If a snoop hit coincides with an LL completing to the same index, link_valid SHALL end at 0.
REQ-031 If a snoop hit coincides with an SC check, the SC SHALL fail.
REQ-032 halt SHALL block only acceptance in IDLE; an in-flight request SHALL complete normally.

Reset
REQ-033 On nRST=0 the block SHALL asynchronously set: state IDLE, counter 0, dhit 0, dmemload 0, link_valid 0, link_idx 0, latched request cleared, and all memory words 0.
REQ-034 A reset asserted during WAIT or RESP SHALL abort the transaction with no write and no dhit.
REQ-035 After reset deassertion, the first request SHALL be accepted in the first IDLE cycle.

Structure
REQ-036 The enum dresp_state_t {IDLE, WAIT, RESP} SHALL live in cpu_types_pkg; word_t SHALL be taken from the same package.
REQ-037 The LL/SC reservation logic SHALL be one sub-module, link_tracker, with inputs set, clear, snoop hit and index, and outputs link_valid and link_idx.
REQ-038 The backing store SHALL be a flop array inside dmem_responder.

Verification
REQ-039 LAT=2: write 0xDEADBEEF to 0x10 then read 0x10 -> dhit 3 cycles after each acceptance; read returns 0xDEADBEEF.
REQ-040 LL 0x20, then SC 0x20 with data 5 -> SC returns 1; a later read of 0x20 returns 5.
REQ-041 LL 0x20, snoop_wen with snoop_addr 0x20, then SC 0x20 with data 7 -> SC returns 0; 0x20 unchanged.
REQ-042 Write accepted, then REN and WEN dropped in the first WAIT cycle -> no dhit, memory unchanged; the next request is served normally.
REQ-043 Assert nRST during WAIT of a write to 0x04 -> outputs are 0 immediately; a later read of 0x04 returns 0.
REQ-044 halt=1 with REN held high for 10 cycles -> no dhit; halt rising during WAIT still gives one dhit.
